// File: rtl/updown_step_pkg.sv
// Shared types and constants for the up/down step sequencer.
package updown_step_pkg;

   localparam int STATE_W = 2;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/step_cnt.sv
// Loadable down-counter holding the number of enables still to issue.
module step_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             is_one
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - 1'b1;  // saturate at zero, never wrap
   end

   assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/updown_step_ctrl.sv
// Command sequencer driving E/x of the 2-bit up/down counter.
// Optional inter-pulse gap cycle enabled by defining UPDOWN_STEP_GAP_EN.
module updown_step_ctrl
   import updown_step_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             pause,
   output logic             E,
   output logic             x,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left
);

   state_t state, state_nxt;
   logic   accept;
   logic   cnt_is_one;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Direction only moves on an accept edge, so it is stable whenever E can fire.
   always_ff @(posedge clk) begin
      if (reset)
         x <= DIR_DOWN;
      else if (accept)
         x <= cmd_dir;
   end

   always_comb begin
      cmd_ready = (state == S_IDLE);
      accept    = cmd_valid & cmd_ready;
      E         = (state == S_RUN) & ~pause;
      busy      = (state == S_RUN) | (state == S_GAP);
      done      = (state == S_DONE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (accept)
               state_nxt = (cmd_steps != '0) ? S_RUN : S_DONE;
         S_RUN:
            if (E) begin
               if (cnt_is_one)
                  state_nxt = S_DONE;
`ifdef UPDOWN_STEP_GAP_EN
               else
                  state_nxt = S_GAP;
`endif
            end
`ifdef UPDOWN_STEP_GAP_EN
         S_GAP:
            state_nxt = S_RUN;
`endif
         S_DONE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   step_cnt #(
      .CNT_W (CNT_W)
   ) u_step_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (cmd_steps),
      .dec      (E),
      .count    (steps_left),
      .is_one   (cnt_is_one)
   );

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Randomized + directed bench for updown_step_ctrl against a pulse-budget model.
module tb_updown_step_ctrl;

   localparam int CNT_W = 8;
`ifdef UPDOWN_STEP_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_steps;
   logic             pause;
   logic             E;
   logic             x;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] steps_left;

   always #5 clk = ~clk;

   updown_step_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .pause      (pause),
      .E          (E),
      .x          (x),
      .busy       (busy),
      .done       (done),
      .steps_left (steps_left)
   );

   // downstream 2-bit up/down counter fed by E/x
   logic [1:0] cnt2;
   always_ff @(posedge clk) begin
      if (reset)
         cnt2 <= 2'd0;
      else if (E)
         cnt2 <= x ? cnt2 + 2'd1 : cnt2 - 2'd1;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Model: a command is a budget of pulses; a pulse cycle in gap mode
   // blanks the following cycle unless it was the last pulse.
   bit m_active, m_blank, m_done, m_dir;
   int m_left;
   int e_pulses;

   task automatic model_reset();
      m_active = 0; m_blank = 0; m_done = 0; m_dir = 0; m_left = 0;
   endtask

   // one clock: apply inputs, check outputs mid-cycle, advance model at the edge
   task automatic cyc(input bit v, input bit d, input int s, input bit p, input bit r);
      bit exp_e;
      cmd_valid = v; cmd_dir = d; cmd_steps = CNT_W'(s); pause = p; reset = r;
      @(negedge clk);
      exp_e = m_active && !m_blank && !p;
      chk("E",          int'(E),          int'(exp_e));
      chk("x",          int'(x),          int'(m_dir));
      chk("busy",       int'(busy),       int'(m_active));
      chk("done",       int'(done),       int'(m_done));
      chk("cmd_ready",  int'(cmd_ready),  int'(!m_active && !m_done));
      chk("steps_left", int'(steps_left), m_left);
      if (E) e_pulses++;
      @(posedge clk);
      if (r) model_reset();
      else if (m_done) m_done = 0;
      else if (!m_active) begin
         if (v) begin
            m_dir  = d;
            m_left = s;
            if (s == 0) m_done = 1;
            else        m_active = 1;
         end
      end else if (m_blank) m_blank = 0;
      else if (!p) begin
         m_left--;
         if (m_left == 0) begin m_active = 0; m_done = 1; end
         else if (GAP) m_blank = 1;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int s;
      model_reset();
      cmd_valid = 0; cmd_dir = 0; cmd_steps = '0; pause = 0; reset = 1;
      @(posedge clk); #1;
      cyc(0, 0, 0, 0, 1);                 // reset state checked here too
      idle(2);

      // 1: up, 3 steps -> downstream count 11
      cyc(1, 1, 3, 0, 0);
      idle(6);
      chk("cnt2_after_up3", int'(cnt2), 3);

      // 2: zero steps
      cyc(1, 1, 0, 0, 0);
      idle(3);

      // 3: pause for 2 cycles after first pulse
      e_pulses = 0;
      cyc(1, 0, 4, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      idle(8);
      chk("pause_pulses", e_pulses, 4);

      // 4: reset after 2 of 5 pulses
      cyc(1, 1, 5, 0, 0);
      idle(2);
      cyc(0, 0, 0, 0, 1);
      idle(3);

      // 5: valid held high through two commands, dir changes while busy
      cyc(1, 1, 2, 0, 0);
      for (int i = 0; i < 10; i++)
         cyc(m_active || m_done || i < 4 ? 1'b1 : 1'b0, 1'b0, 2, 0, 0);
      idle(4);

      // max-length command
      e_pulses = 0;
      cyc(1, 1, (1 << CNT_W) - 1, 0, 0);
      idle(2 * ((1 << CNT_W) - 1) + 4);
      chk("max_pulses", e_pulses, (1 << CNT_W) - 1);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         s = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
         if ($urandom_range(0, 99) == 0) s = $urandom_range(200, 255);
         cyc($urandom_range(0, 1), $urandom_range(0, 1), s,
             $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
